cnn_layer_accel_prefetch_rd_seq: RTL and testbench
==================================================

// Module: cnn_layer_accel_prefetch_rd_seq
//
// PURPOSE
//  Read-side sequencer for the prefetch row buffer. It walks the expanded (padded/upsampled) image one coordinate per
//  cycle and drives the buffer's rd_en/input_col/input_row/rst_addr. It captures the returned pixels after a fixed
//  read latency and delivers them as a valid/ready stream to the convolution datapath. It sits between the prefetch
//  buffer (upstream) and the row-window feeder (downstream), with credit flow control so backpressure never drops data.
//
// PARAMETERS
//  C_RD_LATENCY   2   cycles from pfb_rd_en to valid pfb_dout (buffer rden register + FWFT RAM)
//  C_FIFO_DEPTH   8   output skid FIFO entries; power of 2, >= C_RD_LATENCY + 2
//  (W = clog2(`MAX_NUM_INPUT_COLS), pixel width = `PIXEL_WIDTH, both from cnn_layer_accel_defs.vh)
//
// PORTS
//  clk                 in   1    single clock; all logic on posedge
//  rst_n               in   1    asynchronous, active-low reset
//  job_start           in   1    1-cycle pulse; latches config below, starts walk at (row 0, col 0)
//  padding, upsample   in   1    latched mode bits
//  expd_num_input_cols in   W    expanded width (count); cols run 0..N-1
//  expd_num_input_rows in   W    expanded height (count); rows run 0..M-1
//  row_ready           in   1    level: buffer holds a complete source row
//  row_consumed        out  1    1-cycle pulse: source row finished; upstream may refill
//  pfb_rd_en           out  1    read strobe to prefetch buffer
//  pfb_rst_addr        out  1    1-cycle pulse: rewind buffer read address (upsample row replay)
//  input_col/input_row out  W    coordinate presented with pfb_rd_en
//  pfb_dout            in   `PIXEL_WIDTH  buffer data, valid C_RD_LATENCY after each pfb_rd_en
//  pix_data            out  `PIXEL_WIDTH  output pixel
//  pix_valid / pix_rdy out/in 1  stream handshake; transfer when both high
//  pix_last            out  1    marks last pixel of the job
//  busy / job_done     out  1    busy level; job_done 1-cycle pulse after final transfer
//
// BEHAVIOUR
//  - Reset: FSM IDLE; all outputs 0; counters, FIFO and pipeline cleared. Assertion mid-job aborts immediately, with no
//    job_done.
//  - FSM: IDLE -(job_start)-> WAIT_ROW -(row_ready)-> ISSUE -(last col issued)-> ROW_END -> WAIT_ROW | REPLAY | DRAIN.
//    DRAIN -(FIFO empty, pipeline empty)-> DONE -> IDLE.
//  - ISSUE: one coordinate slot per cycle while credit holds: fifo_count + inflight + 1 <= C_FIFO_DEPTH. With no
//    credit, the slot stalls and col holds.
//  - Slot type: with upsample, odd cols are REUSE slots (pfb_rd_en=0; the last captured pixel is pushed). All other
//    slots are READ (pfb_rd_en=1). Padding zeroes are produced by the buffer; the sequencer always issues READ for
//    them.
//  - Each slot enters a C_RD_LATENCY-deep tag shift register (valid, reuse, last). On exit it pushes exactly one FIFO
//    entry.
//  - ROW_END: with upsample and an even row, pulse pfb_rst_addr and enter REPLAY (1 cycle), then ISSUE. No
//    row_consumed is sent. Otherwise pulse row_consumed. If row == M-1, go to DRAIN; else go to WAIT_ROW.
//  - row/col arithmetic is W-bit unsigned; col wraps to 0 at N-1; no other wrap.
//  - pix_last is set on the entry for (M-1, N-1). job_done fires the cycle after that entry transfers.
//  - job_start while busy is ignored. N or M == 0: go directly to DONE, pulse job_done, emit no pixels.
//  - FIFO full with pix_rdy low is unreachable because of credit. Simultaneous push and pop keep the count unchanged.
//  - Latency: the first pix_valid appears C_RD_LATENCY+1 cycles after the first pfb_rd_en.
//
// CONFIGURATION
//  PREFETCH_RD_SEQ_STALL_CNT_EN: defined -> 32-bit stall_cycles output counts ISSUE cycles blocked by credit; it
//    saturates and clears on job_start. Undefined -> port and counter absent.
//
// STRUCTURE
//  - cnn_layer_accel_defs.vh: FSM state enum (IDLE, WAIT_ROW, ISSUE, ROW_END, REPLAY, DRAIN, DONE) and the tag struct.
//  - One sub-module: cnn_layer_accel_pix_sync_fifo (single-clock, first-word-fall-through, count output).
//
// TESTING
//  1. N=4, M=2, no pad/upsample, pix_rdy=1, buffer returns col index -> 8 pixels 0,1,2,3,0,1,2,3; 2 row_consumed;
//     pix_last on 8th pixel.
//  2. upsample, N=4, M=2, source row {A,B} -> A,A,B,B,A,A,B,B; exactly 1 pfb_rst_addr; 1 row_consumed; 4 pfb_rd_en
//     total.
//  3. N=16, pix_rdy low for 20 cycles mid-row -> at most C_FIFO_DEPTH held; no pixel lost or duplicated; order
//     preserved.
//  4. row_ready held low 10 cycles after first row_consumed -> no pfb_rd_en in that window; resume at col 0.
//  5. rst_n asserted mid-ISSUE -> outputs 0 asynchronously; next job_start yields a full correct job.
//  6. job_start with N=0 -> job_done pulses; pix_valid never asserted; job_start pulse while busy has no effect.

Source files
------------

// File: rtl/cnn_layer_accel_prefetch_rd_seq_pkg.sv
// Shared definitions for the prefetch read sequencer.
//   - Global sizing: MAX_NUM_INPUT_COLS, PIXEL_WIDTH, COORD_W (coordinate width W).
//   - state_t: sequencer FSM states.
//   - tag_t: per-slot tag carried through the read-latency shift register.
package cnn_layer_accel_prefetch_rd_seq_pkg;

  localparam int MAX_NUM_INPUT_COLS = 128;
  localparam int PIXEL_WIDTH        = 16;
  localparam int COORD_W            = $clog2(MAX_NUM_INPUT_COLS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ROW,
    ST_ISSUE,
    ST_ROW_END,
    ST_REPLAY,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // vld: slot occupies this stage; reuse: push last captured pixel instead of
  // buffer data; last: slot is the final pixel of the job.
  typedef struct packed {
    logic vld;
    logic reuse;
    logic last;
  } tag_t;

endpackage

// File: rtl/cnn_layer_accel_pix_sync_fifo.sv
// Single-clock first-word-fall-through FIFO used as the output skid buffer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_din     write strobe and data
//   i_pop             read strobe (only while !o_empty)
//   o_dout            head entry, valid whenever !o_empty
//   o_empty, o_count  status
// DEPTH must be a power of 2; pointers wrap naturally.
module cnn_layer_accel_pix_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd];
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/cnn_layer_accel_prefetch_rd_seq.sv
// Read-side sequencer for the prefetch row buffer. Walks the expanded image one
// coordinate per cycle, strobes the buffer, realigns returned pixels through a
// read-latency tag pipe and hands them out on a valid/ready stream through a
// skid FIFO. Issue is credit-gated so backpressure never drops data.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   i_job_start                         pulse: latch config, start at (0,0)
//   i_padding, i_upsample               mode bits (padding zeros come from the buffer)
//   i_expd_num_input_cols/rows          expanded width/height (counts)
//   i_row_ready / o_row_consumed        source-row handshake with the buffer
//   o_pfb_rd_en, o_pfb_rst_addr         buffer read strobe / read-address rewind
//   o_input_col, o_input_row            coordinate presented with o_pfb_rd_en
//   i_pfb_dout                          buffer data, C_RD_LATENCY after o_pfb_rd_en
//   o_pix_data/valid/last, i_pix_rdy    output pixel stream
//   o_busy, o_job_done                  status level / completion pulse
//   o_stall_cycles                      only with PREFETCH_RD_SEQ_STALL_CNT_EN defined:
//                                       saturating count of credit-blocked ISSUE cycles
module cnn_layer_accel_prefetch_rd_seq
  import cnn_layer_accel_prefetch_rd_seq_pkg::*;
#(
  parameter int C_RD_LATENCY = 2,
  parameter int C_FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_job_start,
  input  logic                   i_padding,
  input  logic                   i_upsample,
  input  logic [COORD_W-1:0]     i_expd_num_input_cols,
  input  logic [COORD_W-1:0]     i_expd_num_input_rows,
  input  logic                   i_row_ready,
  output logic                   o_row_consumed,
  output logic                   o_pfb_rd_en,
  output logic                   o_pfb_rst_addr,
  output logic [COORD_W-1:0]     o_input_col,
  output logic [COORD_W-1:0]     o_input_row,
  input  logic [PIXEL_WIDTH-1:0] i_pfb_dout,
  output logic [PIXEL_WIDTH-1:0] o_pix_data,
  output logic                   o_pix_valid,
  input  logic                   i_pix_rdy,
  output logic                   o_pix_last,
  output logic                   o_busy,
  output logic                   o_job_done
`ifdef PREFETCH_RD_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]            o_stall_cycles
`endif
);

  state_t                   r_state, w_state_nxt;
  logic [COORD_W-1:0]       r_col, r_row, r_n, r_m;
  logic                     r_ups;
  tag_t                     r_tag [C_RD_LATENCY];
  tag_t                     w_tag_in, w_exit;
  logic [PIXEL_WIDTH-1:0]   r_last_pix, w_push_pix, w_fifo_pix;
  logic                     r_job_done;
  logic [7:0]               w_inflight;
  logic [$clog2(C_FIFO_DEPTH):0] w_fifo_cnt;
  logic                     w_fifo_empty, w_fifo_last, w_pop;
  logic                     w_credit, w_slot, w_reuse, w_last_col, w_last_row;
  logic                     w_replay, w_zero_job, w_accept;
  // Padded coordinates are read like any other; the buffer supplies the zeros.
  logic                     w_unused_padding;

  assign w_unused_padding = i_padding;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < C_RD_LATENCY; i++) w_inflight += 8'(r_tag[i].vld);
  end

  // A slot needs room for itself among FIFO entries plus slots still in flight.
  assign w_credit   = (8'(w_fifo_cnt) + w_inflight) < 8'(C_FIFO_DEPTH);
  assign w_slot     = (r_state == ST_ISSUE) && w_credit;
  assign w_reuse    = r_ups && r_col[0];
  assign w_last_col = (r_col == r_n - COORD_W'(1));
  assign w_last_row = (r_row == r_m - COORD_W'(1));
  // Even rows replay the same source row when upsampling; never past the last row.
  assign w_replay   = r_ups && !r_row[0] && !w_last_row;
  assign w_zero_job = (i_expd_num_input_cols == '0) || (i_expd_num_input_rows == '0);
  assign w_accept   = (r_state == ST_IDLE) && i_job_start;

  always_comb begin
    w_state_nxt    = r_state;
    o_pfb_rd_en    = 1'b0;
    o_pfb_rst_addr = 1'b0;
    o_row_consumed = 1'b0;
    case (r_state)
      ST_IDLE:     if (i_job_start) w_state_nxt = w_zero_job ? ST_DONE : ST_WAIT_ROW;
      ST_WAIT_ROW: if (i_row_ready) w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        o_pfb_rd_en = w_slot && !w_reuse;
        if (w_slot && w_last_col) w_state_nxt = ST_ROW_END;
      end
      ST_ROW_END: begin
        if (w_replay) begin
          o_pfb_rst_addr = 1'b1;
          w_state_nxt    = ST_REPLAY;
        end else begin
          o_row_consumed = 1'b1;
          w_state_nxt    = w_last_row ? ST_DRAIN : ST_WAIT_ROW;
        end
      end
      ST_REPLAY:   w_state_nxt = ST_ISSUE;
      ST_DRAIN:    if (w_fifo_empty && (w_inflight == '0)) w_state_nxt = ST_DONE;
      ST_DONE:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_n   <= '0;
      r_m   <= '0;
      r_ups <= 1'b0;
    end else if (w_accept) begin
      r_col <= '0;
      r_row <= '0;
      r_n   <= i_expd_num_input_cols;
      r_m   <= i_expd_num_input_rows;
      r_ups <= i_upsample;
    end else begin
      if (w_slot) r_col <= w_last_col ? '0 : r_col + COORD_W'(1);
      if ((r_state == ST_ROW_END) && (w_replay || !w_last_row)) r_row <= r_row + COORD_W'(1);
    end
  end

  assign w_tag_in = '{vld: w_slot, reuse: w_reuse, last: w_slot && w_last_col && w_last_row};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_RD_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < C_RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // The tag leaving the pipe lines up with the buffer data for its slot.
  assign w_exit     = r_tag[C_RD_LATENCY-1];
  assign w_push_pix = w_exit.reuse ? r_last_pix : i_pfb_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_last_pix <= '0;
    else if (w_exit.vld) r_last_pix <= w_push_pix;
  end

  cnn_layer_accel_pix_sync_fifo #(
    .DEPTH (C_FIFO_DEPTH),
    .WIDTH (PIXEL_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_exit.vld),
    .i_din   ({w_exit.last, w_push_pix}),
    .i_pop   (w_pop),
    .o_dout  ({w_fifo_last, w_fifo_pix}),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  assign o_pix_valid = !w_fifo_empty;
  assign w_pop       = o_pix_valid && i_pix_rdy;
  assign o_pix_data  = o_pix_valid ? w_fifo_pix : '0;
  assign o_pix_last  = o_pix_valid && w_fifo_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_job_done <= 1'b0;
    else        r_job_done <= (w_pop && w_fifo_last) || (w_accept && w_zero_job);
  end

  assign o_job_done  = r_job_done;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_input_col = r_col;
  assign o_input_row = r_row;

`ifdef PREFETCH_RD_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_stall_cycles <= '0;
    else if (w_accept) r_stall_cycles <= '0;
    else if ((r_state == ST_ISSUE) && !w_credit && (r_stall_cycles != '1))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_prefetch_rd_seq.sv
module tb_cnn_layer_accel_prefetch_rd_seq;
  import cnn_layer_accel_prefetch_rd_seq_pkg::*;

  localparam int L = 2;
  localparam int D = 8;

  logic clk, rst_n, job_start, padding, upsample, row_ready, row_consumed;
  logic pfb_rd_en, pfb_rst_addr, pix_valid, pix_rdy, pix_last, busy, job_done;
  logic [COORD_W-1:0]     ncols, nrows, input_col, input_row;
  logic [PIXEL_WIDTH-1:0] pfb_dout, pix_data, d1;

  cnn_layer_accel_prefetch_rd_seq #(.C_RD_LATENCY(L), .C_FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .i_job_start(job_start), .i_padding(padding),
    .i_upsample(upsample), .i_expd_num_input_cols(ncols), .i_expd_num_input_rows(nrows),
    .i_row_ready(row_ready), .o_row_consumed(row_consumed), .o_pfb_rd_en(pfb_rd_en),
    .o_pfb_rst_addr(pfb_rst_addr), .o_input_col(input_col), .o_input_row(input_row),
    .i_pfb_dout(pfb_dout), .o_pix_data(pix_data), .o_pix_valid(pix_valid),
    .i_pix_rdy(pix_rdy), .o_pix_last(pix_last), .o_busy(busy), .o_job_done(job_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [PIXEL_WIDTH-1:0] d; logic l;} exp_t;
  exp_t sb[$];

  int n_tests = 0, n_fail = 0, cyc = 0, start_cyc = 0;
  int g_ups = 0, g_seed = 0, g_smul = 0, g_gap = 2, g_rmode = 0;
  int srow = 0, ptr = 0, gap_cnt = 0;
  int rd_cnt, rc_cnt, ra_cnt, done_cnt, xfer, first_rd, first_pv, occ_bad;
  int exp_rd, exp_rc, exp_ra;
  bit done_expect = 0;

  // Source image content as held by the prefetch buffer.
  function automatic logic [PIXEL_WIDTH-1:0] src(int s, int i);
    return PIXEL_WIDTH'(g_seed + s * g_smul + i);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Prefetch buffer model: one source row at a time, sequential read pointer,
  // rewind on rst_addr, refill after row_consumed with a configurable gap.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srow <= 0; ptr <= 0; row_ready <= 1'b0; gap_cnt <= 0;
      d1 <= '0; pfb_dout <= '0;
    end else begin
      pfb_dout <= d1;
      d1 <= pfb_rd_en ? src(srow, ptr) : 16'hDEAD;
      if (job_start && !busy) begin
        srow <= 0; ptr <= 0; row_ready <= 1'b0; gap_cnt <= 2;
      end else begin
        if (pfb_rd_en) ptr <= ptr + 1;
        if (pfb_rst_addr) ptr <= 0;
        if (row_consumed) begin
          srow <= srow + 1; ptr <= 0; row_ready <= 1'b0; gap_cnt <= g_gap;
        end else if (!row_ready && busy) begin
          if (gap_cnt == 0) row_ready <= 1'b1;
          else gap_cnt <= gap_cnt - 1;
        end
      end
    end
  end

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (g_rmode)
      0:       pix_rdy = 1'b1;
      1:       pix_rdy = ($urandom_range(0, 3) != 0);
      default: pix_rdy = !((cyc - start_cyc) >= 10 && (cyc - start_cyc) < 30);
    endcase
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_expect) begin
        n_tests++;
        if (job_done !== 1'b1) begin
          n_fail++;
          $display("FAIL job_done_timing: job_done=%0b required 1", job_done);
        end
        done_expect = 0;
      end
      if (pfb_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        n_tests++;
        if (!row_ready || int'(input_col) != (g_ups != 0 ? 2 * ptr : ptr)) begin
          n_fail++;
          $display("FAIL rd_gate: row_ready=%0b col=%0d required ready=1 col=%0d",
                   row_ready, input_col, (g_ups != 0 ? 2 * ptr : ptr));
        end
      end
      if (g_ups == 0 && (rd_cnt - xfer) > D) occ_bad = 1;
      if (row_consumed) rc_cnt++;
      if (pfb_rst_addr) ra_cnt++;
      if (job_done) done_cnt++;
      if (pix_valid && first_pv < 0) first_pv = cyc;
      if (pix_valid && pix_rdy) begin
        xfer++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pixel: data=%h with nothing expected", pix_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (pix_data !== e.d || pix_last !== e.l) begin
            n_fail++;
            $display("FAIL pixel: data=%h last=%0b required data=%h last=%0b",
                     pix_data, pix_last, e.d, e.l);
          end
          if (e.l) done_expect = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic start_job(input int n, m, ups, seed, smul, gap, rmode);
    g_ups = ups; g_seed = seed; g_smul = smul; g_gap = gap; g_rmode = rmode;
    sb.delete();
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++)
        sb.push_back('{d: src(ups != 0 ? r / 2 : r, ups != 0 ? c / 2 : c),
                       l: (r == m - 1 && c == n - 1)});
    exp_rd = m * (ups != 0 ? (n + 1) / 2 : n);
    exp_ra = 0;
    if (ups != 0) for (int r = 0; r < m - 1; r++) if (r % 2 == 0) exp_ra++;
    exp_rc = (n == 0 || m == 0) ? 0 : m - exp_ra;
    if (n == 0 || m == 0) exp_ra = 0;
    rd_cnt = 0; rc_cnt = 0; ra_cnt = 0; done_cnt = 0; xfer = 0;
    first_rd = -1; first_pv = -1; occ_bad = 0; done_expect = 0;
    @(negedge clk);
    ncols = COORD_W'(n); nrows = COORD_W'(m); upsample = ups[0];
    padding = 1'($urandom_range(0, 1));
    job_start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    job_start = 1'b0;
  endtask

  task automatic finish_job(input string nm);
    int k = 0;
    while (!job_done && k < 5000) begin @(negedge clk); k++; end
    if (!job_done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: job_done=0 after %0d cycles required 1", nm, k);
    end
    repeat (3) @(negedge clk);
    chk({nm, "_sb_empty"}, sb.size(), 0);
    chk({nm, "_rd_en"}, rd_cnt, exp_rd);
    chk({nm, "_row_consumed"}, rc_cnt, exp_rc);
    chk({nm, "_rst_addr"}, ra_cnt, exp_ra);
    chk({nm, "_job_done"}, done_cnt, 1);
    chk({nm, "_occupancy"}, occ_bad, 0);
    if (exp_rd > 0) chk({nm, "_latency"}, first_pv - first_rd, L + 1);
    else            chk({nm, "_no_pixels"}, xfer, 0);
  endtask

  function automatic logic [63:0] outs();
    return 64'({pix_valid, pix_last, busy, job_done, pfb_rd_en, pfb_rst_addr,
                row_consumed, input_col, input_row, pix_data});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; job_start = 1'b0; padding = 1'b0; upsample = 1'b0;
    ncols = '0; nrows = '0; pix_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(outs() != 0), 0);
    rst_n = 1'b1;

    // 1: plain walk, buffer returns column index
    start_job(4, 2, 0, 0, 0, 2, 0);   finish_job("t1_plain");
    // 2: upsample with row replay
    start_job(4, 2, 1, 16, 100, 2, 0); finish_job("t2_upsample");
    // 3: long downstream stall mid-row
    start_job(16, 2, 0, 500, 37, 2, 2); finish_job("t3_backpressure");
    // 4: row_ready gap after each consumed row
    start_job(8, 3, 0, 900, 37, 10, 0); finish_job("t4_row_gap");

    // 5: asynchronous reset mid-ISSUE, then a clean job
    start_job(12, 3, 0, 1200, 37, 2, 0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_reset_outputs", int'(outs() != 0), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_job(12, 3, 1, 1300, 37, 2, 1); finish_job("t5_after_reset");

    // 6: empty job and an ignored start while busy
    start_job(0, 3, 0, 0, 0, 2, 0); finish_job("t6_zero");
    start_job(6, 2, 0, 2000, 37, 2, 0);
    repeat (4) @(negedge clk);
    ncols = COORD_W'(3); nrows = COORD_W'(1); upsample = 1'b1; job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    finish_job("t6_busy_start");

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      start_job($urandom_range(1, 20), $urandom_range(1, 5), $urandom_range(0, 1),
                $urandom_range(0, 50000), 37, $urandom_range(0, 6), 1);
      finish_job("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
